// File: rtl/step_seq_pkg.sv
// step_seq_pkg: default parameters, width helpers and channel slicing for step_seq_gen
package step_seq_pkg;
    localparam int DEF_PERIOD  = 32;
    localparam int DEF_FRAME   = 33;
    localparam int DEF_NCH     = 2;
    localparam int DEF_PULSE_W = 4;

    function automatic int cw_of(input int period);
        return (period > 2) ? $clog2(period) : 1;
    endfunction

    function automatic int iw_of(input int frame);
        return (frame > 2) ? $clog2(frame) : 1;
    endfunction

    // Low bit of channel k inside a packed NCH*IW index bus
    function automatic int ch_lo(input int k, input int iw);
        return k * iw;
    endfunction
endpackage

// File: rtl/step_seq_if.sv
// step_seq_if: control/status bundle of step_seq_gen
//   master drives en, clr, oneshot, ev_on, ev_off; slave drives step, step_idx, frame_wrap, ev, done
interface step_seq_if #(
    parameter int NCH = 2,
    parameter int IW  = 6
);
    logic              en;
    logic              clr;
    logic              oneshot;
    logic [NCH*IW-1:0] ev_on;
    logic [NCH*IW-1:0] ev_off;
    logic              step;
    logic [IW-1:0]     step_idx;
    logic              frame_wrap;
    logic [NCH-1:0]    ev;
    logic              done;

    modport master (
        output en, clr, oneshot, ev_on, ev_off,
        input  step, step_idx, frame_wrap, ev, done
    );

    modport slave (
        input  en, clr, oneshot, ev_on, ev_off,
        output step, step_idx, frame_wrap, ev, done
    );
endinterface

// File: rtl/step_seq_evch.sv
// step_seq_evch: one event channel, set/cleared when the new step index hits its on/off index
//   clk, rst (async high), clr (sync), upd (step edge), idx (new step index),
//   on_idx/off_idx (programmed indices), ev (event level)
module step_seq_evch #(
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          upd,
    input  logic [IW-1:0] idx,
    input  logic [IW-1:0] on_idx,
    input  logic [IW-1:0] off_idx,
    output logic          ev
);
    logic ev_q, ev_d;

    // off is tested first so on==off leaves the channel low
    always_comb begin
        ev_d = clr ? 1'b0 : !upd ? ev_q : (idx == off_idx) ? 1'b0 : (idx == on_idx) ? 1'b1 : ev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ev_q <= 1'b0;
        else     ev_q <= ev_d;
    end

    assign ev = ev_q;
endmodule

// File: rtl/step_seq_gen.sv
// step_seq_gen: step pulse every PERIOD enabled clocks, wrapping step index and NCH event lines
//   CCLK, rst (async high), bus (step_seq_if.slave: en/clr/oneshot/ev_on/ev_off in,
//   step/step_idx/frame_wrap/ev/done out)
//   STEP_SEQ_STRETCH_EN: stretch step to PULSE_W cycles
module step_seq_gen
    import step_seq_pkg::*;
#(
    parameter int PERIOD  = DEF_PERIOD,
    parameter int FRAME   = DEF_FRAME,
    parameter int NCH     = DEF_NCH,
    parameter int PULSE_W = DEF_PULSE_W
) (
    input logic      CCLK,
    input logic      rst,
    step_seq_if.slave bus
);
    localparam int CW = cw_of(PERIOD);
    localparam int IW = iw_of(FRAME);

    if (PERIOD < 2 || FRAME < 2 || NCH < 1 || PULSE_W < 1 || PULSE_W >= PERIOD) begin : g_bad_cfg
        $error("step_seq_gen: illegal parameter set");
    end

    logic [CW-1:0]  cyc_q, cyc_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           step_q, step_d;
    logic           wrap_q, wrap_d;
    logic           done_q, done_d;
    logic [NCH-1:0] ev_w;
    logic           run, adv, last;

    assign run  = bus.en && !bus.clr && !done_q;
    assign adv  = run && (cyc_q == CW'(PERIOD - 1));
    assign last = idx_q == IW'(FRAME - 1);

    always_comb begin
        cyc_d  = bus.clr ? '0 : !run ? cyc_q : adv ? '0 : cyc_q + 1'b1;
        idx_d  = bus.clr ? '0 : !adv ? idx_q : last ? '0 : idx_q + 1'b1;
        wrap_d = adv && last;
        done_d = !bus.clr && (done_q || (adv && last && bus.oneshot));
    end

`ifdef STEP_SEQ_STRETCH_EN
    localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    logic [PW-1:0] pw_q, pw_d;

    // pw counts remaining extra cycles; en low freezes both the count and the step level
    always_comb begin
        pw_d   = bus.clr ? '0 : adv ? PW'(PULSE_W - 1) : (step_q && bus.en && pw_q != '0) ? pw_q - 1'b1 : pw_q;
        step_d = bus.clr ? 1'b0 : adv ? 1'b1 : step_q && (!bus.en || pw_q != '0);
    end

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) pw_q <= '0;
        else     pw_q <= pw_d;
    end
`else
    assign step_d = adv;
`endif

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            cyc_q  <= '0;
            idx_q  <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            idx_q  <= idx_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        step_seq_evch #(.IW(IW)) u_ch (
            .clk    (CCLK),
            .rst    (rst),
            .clr    (bus.clr),
            .upd    (adv),
            .idx    (idx_d),
            .on_idx (bus.ev_on[ch_lo(k, IW) +: IW]),
            .off_idx(bus.ev_off[ch_lo(k, IW) +: IW]),
            .ev     (ev_w[k])
        );
    end

    assign bus.step       = step_q;
    assign bus.step_idx   = idx_q;
    assign bus.frame_wrap = wrap_q;
    assign bus.ev         = ev_w;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_step_seq_gen.sv
// tb_step_seq_gen: randomized bench for step_seq_gen against an enabled-cycle-count reference model
module tb_step_seq_gen;
    import step_seq_pkg::*;

    localparam int PERIOD  = 32;
    localparam int FRAME   = 33;
    localparam int NCH     = 2;
    localparam int PULSE_W = 4;
    localparam int IW      = iw_of(FRAME);

    logic CCLK = 1'b0;
    logic rst  = 1'b1;
    always #5 CCLK = ~CCLK;

    step_seq_if #(.NCH(NCH), .IW(IW)) bus ();

    step_seq_gen #(.PERIOD(PERIOD), .FRAME(FRAME), .NCH(NCH), .PULSE_W(PULSE_W)) dut (
        .CCLK(CCLK),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: everything derives from the number of enabled cycles since the last clear
    int             ecnt, nst, left, m_idx;
    logic           m_step, m_wrap, m_done;
    logic [NCH-1:0] m_ev;
    logic           os;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        ecnt = 0; nst = 0; left = 0; m_idx = 0;
        m_step = 0; m_wrap = 0; m_done = 0; m_ev = '0;
    endtask

    task automatic model_edge();
        logic new_step;
        if (bus.clr) begin
            model_reset();
            return;
        end
        new_step = 0;
        if (bus.en && !m_done) begin
            ecnt++;
            new_step = (ecnt % PERIOD) == 0;
        end
        m_wrap = 0;
        if (new_step) begin
            nst++;
            m_idx  = nst % FRAME;
            m_wrap = m_idx == 0;
            if (m_wrap && bus.oneshot) m_done = 1;
            for (int k = 0; k < NCH; k++) begin
                if (m_idx == int'(bus.ev_off[k*IW +: IW]))     m_ev[k] = 0;
                else if (m_idx == int'(bus.ev_on[k*IW +: IW])) m_ev[k] = 1;
            end
        end
        if (new_step) left = PULSE_W;
        else if (left > 0 && bus.en) left--;
`ifdef STEP_SEQ_STRETCH_EN
        m_step = left > 0;
`else
        m_step = new_step;
`endif
    endtask

    task automatic check_all();
        chk("step", 32'(bus.step), 32'(m_step));
        chk("step_idx", 32'(bus.step_idx), 32'(m_idx));
        chk("frame_wrap", 32'(bus.frame_wrap), 32'(m_wrap));
        chk("ev", 32'(bus.ev), 32'(m_ev));
        chk("done", 32'(bus.done), 32'(m_done));
    endtask

    task automatic cyc(input logic e, input logic c, input logic o);
        @(negedge CCLK);
        bus.en = e; bus.clr = c; bus.oneshot = o;
        @(posedge CCLK);
        model_edge();
        #1 check_all();
    endtask

    task automatic async_reset();
        @(negedge CCLK);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge CCLK);
        bus.en = 0; bus.clr = 0;
        rst = 1'b0;
    endtask

    initial begin
        bus.en = 0; bus.clr = 0; bus.oneshot = 0;
        bus.ev_on  = {6'd12, 6'd11};
        bus.ev_off = {6'd13, 6'd12};
        model_reset();
        #12 check_all();
        @(negedge CCLK) rst = 1'b0;
        // Free run past one full frame wrap
        repeat (33 * PERIOD + 40) cyc(1, 0, 0);
        // One-shot: wait for done (bounded), then confirm it freezes
        for (int i = 0; i < 40 * PERIOD && !m_done; i++) cyc(1, 0, 1);
        chk("done_reached", 32'(bus.done), 32'd1);
        repeat (200) cyc(1, 0, 1);
        cyc(1, 1, 0);
        repeat (PERIOD + 2) cyc(1, 0, 0);
        // Pause for 50 cycles at cyc_cnt=10
        cyc(1, 1, 0);
        repeat (10) cyc(1, 0, 0);
        repeat (50) cyc(0, 0, 0);
        repeat (PERIOD + 2) cyc(1, 0, 0);
        // clr on the cycle that would wrap the period counter
        cyc(1, 1, 0);
        repeat (PERIOD - 1) cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("clr_at_wrap_no_step", 32'(bus.step), 32'd0);
        repeat (PERIOD + 2) cyc(1, 0, 0);
        // Channel 0 with on==off stays low
        bus.ev_on[0 +: IW]  = 6'd5;
        bus.ev_off[0 +: IW] = 6'd5;
        repeat (8 * PERIOD) cyc(1, 0, 0);
        async_reset();
        // Random mix: pauses, rare clears, one-shot, async resets, index changes (incl. >= FRAME)
        os = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                bus.ev_on  = NCH*IW'($urandom);
                bus.ev_off = NCH*IW'($urandom);
            end
            if ($urandom_range(0, 499) == 0) os = ~os;
            if ($urandom_range(0, 999) == 0) async_reset();
            else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 299) == 0, os);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/step_seq_gen.md
Name: step_seq_gen

Overview:
- Synthesizable, parametrised step-and-event sequencer for driving the MIPS board's debug inputs.
- Emits a one-cycle single-step pulse every PERIOD enabled clocks and keeps a wrapping step index 0..FRAME-1.
- Drives NCH event lines, each raised and lowered at programmable step indices.
- Sits between the board clock and mips_top's step/mode inputs, on the board or in benches; adds pause, clear, one-shot frames and multiple channels.

Parameters:
- PERIOD, 32, enabled clock cycles between step pulses (must be ≥2).
- FRAME, 33, step indices per frame; index wraps FRAME-1 → 0 (must be ≥2).
- NCH, 2, number of event channels (≥1).
- PULSE_W, 4, step pulse width in cycles; used only with the optional feature (1 ≤ PULSE_W < PERIOD).

Ports:
- CCLK, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, run enable; low pauses all counters.
- clr, in, 1, synchronous clear of counters, events and done; takes priority over en.
- oneshot, in, 1, 1 = stop after one full frame; sampled at each frame wrap.
- ev_on, in, NCH*IW, per-channel set index, channel k at bits [k*IW +: IW], IW = $clog2(FRAME).
- ev_off, in, NCH*IW, per-channel clear index, same packing.
- step, out, 1, step pulse.
- step_idx, out, IW, current step index.
- frame_wrap, out, 1, one-cycle pulse coincident with the step that wraps step_idx to 0.
- ev, out, NCH, per-channel event levels.
- done, out, 1, sticky one-shot completion flag.

Behaviour:
- Reset (async, rst=1): cyc_cnt=0, step=0, step_idx=0, frame_wrap=0, ev=0, done=0.
- cyc_cnt (CW = $clog2(PERIOD)):
  - Advances when en=1, clr=0 and done=0.
  - At PERIOD-1 it wraps to 0, and step is registered high for exactly the next cycle.
  - So the first step appears PERIOD cycles after en first rises, then every PERIOD cycles.
- On each step, in the same cycle step is high:
  - step_idx becomes (step_idx==FRAME-1) ? 0 : step_idx+1.
  - ev[k] is updated from the new step_idx: set if it equals ev_on[k], cleared if it equals ev_off[k].
  - If ev_on[k]==ev_off[k], clear wins and ev[k] stays 0.
  - Indices ≥ FRAME never match, so that channel is inert.
- frame_wrap is high together with the step that moves step_idx to 0.
  - If oneshot=1 at that step, done is set on the same edge.
  - While done=1: the counters freeze and no further steps occur; step_idx stays 0 and ev holds its value.
- done clears only on clr or rst. en=0 does not clear done.
- en=0: cyc_cnt, step_idx and ev hold; step=0. Resuming continues the same period count; no extra or lost step.
- clr=1 (synchronous): same values as reset, regardless of en. clr in the same cycle as a wrap means clr wins and no step is issued.
- ev_on/ev_off are sampled only at step edges; they may change at any time without glitching ev.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously).

Optional Feature:
- Macro STEP_SEQ_STRETCH_EN.
- Defined:
  - step stays high for PULSE_W consecutive cycles, starting at the same cycle as the unstretched pulse.
  - step_idx, ev and frame_wrap still update only once, on the first cycle; frame_wrap stays one cycle.
  - en=0 during a pulse holds step at its current level and pauses the width counter.
- Undefined: step is a single cycle and PULSE_W is ignored.

Decomposition:
- Package step_seq_pkg holds the width helper functions (CW and IW derivation from PERIOD/FRAME) and the channel-slice localparams.
- One natural sub-module, step_seq_evch: a single event channel (compare and set/clear register), instantiated NCH times in a generate loop.
- The period counter, index counter and done logic live in the top.

Test Plan (defaults, ev_on={12,11}, ev_off={13,12}, i.e. ev0 on 11/off 12, ev1 on 12/off 13):
- Release rst with en=1 → first step at cycle 32 after en, steps every 32 cycles, step_idx=1,2,… on successive steps.
- 11th step → ev[0]=1, step_idx=11; 12th step → ev[0]=0, ev[1]=1; 13th step → ev[1]=0.
- 33rd step → step_idx 32→0 with frame_wrap=1 on the same cycle; the next step gives step_idx=1.
- oneshot=1 → done=1 at the 33rd step and no further steps over 200 cycles; then clr → done=0, step_idx=0, next step 32 cycles later.
- en low for 50 cycles at cyc_cnt=10 → next step delayed by exactly 50 cycles; ev unchanged. clr coincident with a wrap → no step issued.
- Set ev_on[0]=ev_off[0]=5 → ev[0] never asserts. With STEP_SEQ_STRETCH_EN, step is high for 4 cycles and step_idx increments once per pulse.
